// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a rotating priority pointer, grant locking while the
// holder keeps requesting, and a bounded hold time (MAX_HOLD=0 disables the bound).
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_valid
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               valid_reg, valid_next;
  logic [N-1:0]       grant_reg, grant_next;

  logic [IDX_W-1:0]   after_holder;
  logic [IDX_W-1:0]   search_start;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  assign after_holder = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
  assign search_start = (state_reg == IDLE) ? ptr_reg : after_holder;

  // Wrap-around priority encode: descending scan so the lowest offset from
  // search_start is the last (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(search_start) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(search_start) + i) % N);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          idx_next   = win_idx;
          valid_next = 1'b1;
          cnt_next   = '0;
        end else begin
          idx_next   = '0;
          valid_next = 1'b0;
        end
      end
      GRANT: begin
        if (i_req[idx_reg] && (MAX_HOLD == 0 || cnt_reg != CNT_LAST)) begin
          cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
        end else begin
          // Release or preempt: the holder drops to lowest priority.
          ptr_next = after_holder;
          cnt_next = '0;
          if (win_found) begin
            idx_next   = win_idx;
            valid_next = 1'b1;
          end else begin
            state_next = IDLE;
            idx_next   = '0;
            valid_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_next[gi] = valid_next && (idx_next == IDX_W'(gi));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      grant_reg <= grant_next;
    end
  end

  assign o_grant     = grant_reg;
  assign o_grant_idx = idx_reg;
  assign o_valid     = valid_reg;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with N=4, MAX_HOLD=4; inputs change and
// outputs are sampled on the falling edge.
module tb_round_robin_arbiter;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_req;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_valid;

  int tests = 0;
  int fails = 0;

  round_robin_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .o_grant    (o_grant),
    .o_grant_idx(o_grant_idx),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  // Apply a request vector for exactly one rising edge.
  task automatic step(input logic [3:0] req);
    i_req = req;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(4'b0000);
    i_reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_grant,
                       input logic [1:0] exp_idx, input logic exp_valid);
    tests++;
    assert (o_grant === exp_grant) else begin
      fails++;
      $error("FAIL %s grant: got %b expected %b", tag, o_grant, exp_grant);
    end
    tests++;
    assert (o_valid === exp_valid) else begin
      fails++;
      $error("FAIL %s valid: got %b expected %b", tag, o_valid, exp_valid);
    end
    if (exp_valid) begin
      tests++;
      assert (o_grant_idx === exp_idx) else begin
        fails++;
        $error("FAIL %s idx: got %0d expected %0d", tag, o_grant_idx, exp_idx);
      end
    end
    $display("[TB] %s req=%b grant=%b idx=%0d valid=%b", tag, i_req, o_grant, o_grant_idx, o_valid);
  endtask

  initial begin
    i_reset = 1'b1;
    i_req   = 4'b1111;
    @(negedge clk);

    // 1. Reset with all requests high, then first grant
    step(4'b1111);
    check("reset_hold", 4'b0000, 2'd0, 1'b0);
    tests++;
    assert (o_grant_idx === 2'd0) else begin
      fails++;
      $error("FAIL reset_idx: got %0d expected 0", o_grant_idx);
    end
    i_reset = 1'b0;
    step(4'b1111);
    check("reset_release", 4'b0001, 2'd0, 1'b1);

    // 2. Rotation: each holder keeps the grant exactly 4 cycles, no bubbles
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [1:0] ei;
        logic [3:0] eg;
        ei = 2'(r % 4);
        eg = 4'b0001 << ei;
        check($sformatf("rotate_r%0d_c%0d", r, c), eg, ei, 1'b1);
        step(4'b1111);
      end
    end
    check("rotate_after", 4'b0010, 2'd1, 1'b1);

    // 3. Release handover
    do_reset();
    step(4'b0101);
    check("handover_start", 4'b0001, 2'd0, 1'b1);
    step(4'b0100);
    check("handover_to2", 4'b0100, 2'd2, 1'b1);
    step(4'b0001);
    check("handover_to0", 4'b0001, 2'd0, 1'b1);

    // 4. Sole requester is preempted onto itself without dropping
    do_reset();
    step(4'b1000);
    check("sole_first", 4'b1000, 2'd3, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step(4'b1000);
      check($sformatf("sole_c%0d", c), 4'b1000, 2'd3, 1'b1);
    end
    step(4'b0110);
    check("sole_release", 4'b0010, 2'd1, 1'b1);

    // 5. Wrap from ptr=3 to idx 0, then idle, then grant from IDLE uses ptr=1
    do_reset();
    step(4'b0100);
    check("wrap_hold2", 4'b0100, 2'd2, 1'b1);
    step(4'b0011);
    check("wrap_to0", 4'b0001, 2'd0, 1'b1);
    step(4'b0000);
    check("wrap_idle", 4'b0000, 2'd0, 1'b0);
    step(4'b0011);
    check("idle_ptr1", 4'b0010, 2'd1, 1'b1);

    // 6. Reset in the middle of a grant
    do_reset();
    step(4'b0100);
    step(4'b0100);
    check("midreset_grant2", 4'b0100, 2'd2, 1'b1);
    i_reset = 1'b1;
    step(4'b0100);
    check("midreset_cleared", 4'b0000, 2'd0, 1'b0);
    tests++;
    assert (o_grant_idx === 2'd0) else begin
      fails++;
      $error("FAIL midreset_idx: got %0d expected 0", o_grant_idx);
    end
    i_reset = 1'b0;
    step(4'b0110);
    check("midreset_ptr0", 4'b0010, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
